// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares a single ALU among NREQ requesters. An idle arbiter picks the next
// requesting index in round-robin order (starting just after the last
// serviced owner), captures that requester's opcode and operands, pulses
// alu_start, waits for alu_done and returns the result to the owner as a
// one-cycle rsp_valid pulse. Each operation takes at least 3 cycles
// (IDLE -> WAIT -> RESP).
//
// Optional feature (compile-time macro ALU_ARB_TIMEOUT_EN):
//   A watchdog counts WAIT cycles without alu_done. After TIMEOUT_CYC such
//   cycles the owner gets an error response (rsp_err=1, rsp_data=0).
//   Without the macro WAIT lasts until alu_done and rsp_err is always 0.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   synchronous active-low reset
//   req         in   per-requester request level [NREQ]
//   req_op      in   packed opcodes, requester i at [i*OP_W +: OP_W]
//   req_a/b     in   packed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt         out  one-hot grant pulse (operands captured)
//   alu_op/a/b  out  captured opcode/operands, held through WAIT
//   alu_start   out  one-cycle ALU start pulse
//   alu_result  in   ALU result, sampled only with alu_done in WAIT
//   alu_done    in   ALU completion strobe
//   rsp_valid   out  one-hot response pulse to the owner
//   rsp_data    out  result, valid with rsp_valid
//   rsp_err     out  timeout flag, valid with rsp_valid
//   busy        out  high in WAIT and RESP
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 32,
    parameter int OP_W        = 3,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*OP_W-1:0]   req_op,
    input  logic [NREQ*WIDTH-1:0]  req_a,
    input  logic [NREQ*WIDTH-1:0]  req_b,
    output logic [NREQ-1:0]        gnt,
    output logic [OP_W-1:0]        alu_op,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic                   alu_start,
    input  logic [WIDTH-1:0]       alu_result,
    input  logic                   alu_done,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   rsp_err,
    output logic                   busy
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Reject out-of-range configurations at elaboration time.
    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("alu_share_arbiter: NREQ must be 2..8 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PTR_W-1:0]      r_ptr;
    logic [PTR_W-1:0]      w_ptr_nxt;
    logic [PTR_W-1:0]      r_owner;
    logic [PTR_W-1:0]      w_owner_nxt;
    logic [NREQ-1:0]       r_gnt;
    logic [NREQ-1:0]       w_gnt_nxt;
    logic [OP_W-1:0]       r_alu_op;
    logic [OP_W-1:0]       w_alu_op_nxt;
    logic [WIDTH-1:0]      r_alu_a;
    logic [WIDTH-1:0]      w_alu_a_nxt;
    logic [WIDTH-1:0]      r_alu_b;
    logic [WIDTH-1:0]      w_alu_b_nxt;
    logic                  r_alu_start;
    logic                  w_alu_start_nxt;
    logic [NREQ-1:0]       r_rsp_valid;
    logic [NREQ-1:0]       w_rsp_valid_nxt;
    logic [WIDTH-1:0]      r_rsp_data;
    logic [WIDTH-1:0]      w_rsp_data_nxt;
    logic                  r_rsp_err;
    logic                  w_rsp_err_nxt;
    logic                  r_busy;
    logic                  w_busy_nxt;

    // Arbitration result and the winner's captured fields
    logic                  w_found;
    logic [PTR_W-1:0]      w_win;
    logic [OP_W-1:0]       w_sel_op;
    logic [WIDTH-1:0]      w_sel_a;
    logic [WIDTH-1:0]      w_sel_b;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0]       r_wd_cnt;
    logic [WD_W-1:0]       w_wd_cnt_nxt;
`endif

    // Round-robin search: first asserted req from ptr+1 upward, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!w_found && req[PTR_W'((int'(r_ptr) + i) % NREQ)]) begin
                w_found = 1'b1;
                w_win   = PTR_W'((int'(r_ptr) + i) % NREQ);
            end else begin
                w_found = w_found;
            end
        end
    end

    // AND-OR mux selecting the winner's opcode and operands.
    always_comb begin
        w_sel_op = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sel_op = w_sel_op | ({OP_W{w_win == PTR_W'(i)}}  & req_op[i*OP_W +: OP_W]);
            w_sel_a  = w_sel_a  | ({WIDTH{w_win == PTR_W'(i)}} & req_a[i*WIDTH +: WIDTH]);
            w_sel_b  = w_sel_b  | ({WIDTH{w_win == PTR_W'(i)}} & req_b[i*WIDTH +: WIDTH]);
        end
    end

    // FSM next-state and next-output logic; pulses default low, data holds.
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_owner_nxt     = r_owner;
        w_gnt_nxt       = '0;
        w_alu_start_nxt = 1'b0;
        w_alu_op_nxt    = r_alu_op;
        w_alu_a_nxt     = r_alu_a;
        w_alu_b_nxt     = r_alu_b;
        w_rsp_valid_nxt = '0;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_err_nxt   = 1'b0;
        w_busy_nxt      = r_busy;
`ifdef ALU_ARB_TIMEOUT_EN
        w_wd_cnt_nxt    = r_wd_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_gnt_nxt[w_win] = 1'b1;
                    w_alu_start_nxt  = 1'b1;
                    w_alu_op_nxt     = w_sel_op;
                    w_alu_a_nxt      = w_sel_a;
                    w_alu_b_nxt      = w_sel_b;
                    w_owner_nxt      = w_win;
                    w_busy_nxt       = 1'b1;
                    w_state_nxt      = ST_WAIT;
`ifdef ALU_ARB_TIMEOUT_EN
                    w_wd_cnt_nxt     = '0;
`endif
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // done is honoured even in the alu_start cycle (zero-wait ALU)
                // and wins over a watchdog expiring in the same cycle.
                if (alu_done) begin
                    w_rsp_valid_nxt[r_owner] = 1'b1;
                    w_rsp_data_nxt           = alu_result;
                    w_rsp_err_nxt            = 1'b0;
                    w_ptr_nxt                = r_owner;
                    w_state_nxt              = ST_RESP;
                end
`ifdef ALU_ARB_TIMEOUT_EN
                // Count value before this cycle's increment; the compare
                // fires in the TIMEOUT_CYC-th WAIT cycle without done.
                else if (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
                    w_rsp_valid_nxt[r_owner] = 1'b1;
                    w_rsp_data_nxt           = '0;
                    w_rsp_err_nxt            = 1'b1;
                    w_ptr_nxt                = r_owner;
                    w_state_nxt              = ST_RESP;
                end else begin
                    w_wd_cnt_nxt = r_wd_cnt + WD_W'(1);
                    w_state_nxt  = ST_WAIT;
                end
`else
                else begin
                    w_state_nxt = ST_WAIT;
                end
`endif
            end
            ST_RESP: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= PTR_W'(NREQ - 1);
            r_owner     <= '0;
            r_gnt       <= '0;
            r_alu_start <= 1'b0;
            r_alu_op    <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
            r_wd_cnt    <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_gnt       <= w_gnt_nxt;
            r_alu_start <= w_alu_start_nxt;
            r_alu_op    <= w_alu_op_nxt;
            r_alu_a     <= w_alu_a_nxt;
            r_alu_b     <= w_alu_b_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_busy      <= w_busy_nxt;
`ifdef ALU_ARB_TIMEOUT_EN
            r_wd_cnt    <= w_wd_cnt_nxt;
`endif
        end
    end

    assign gnt       = r_gnt;
    assign alu_op    = r_alu_op;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_start = r_alu_start;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Scoreboard bench. The driver decides each winner with a round-robin
// reference model (next asserted index after the last owner), computes the
// expected result with its own ALU function and queues grant/response
// expectations. A monitor on the falling edge pops and compares whenever the
// DUT presents gnt or rsp_valid. A behavioural ALU answers alu_start after a
// programmable latency, or never (hang), and can inject stray done pulses.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int OP_W  = 3;

    typedef struct {
        int               w;
        logic [OP_W-1:0]  op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
        logic             err;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*OP_W-1:0]  req_op;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       gnt;
    logic [OP_W-1:0]       alu_op;
    logic [WIDTH-1:0]      alu_a;
    logic [WIDTH-1:0]      alu_b;
    logic                  alu_start;
    logic [WIDTH-1:0]      alu_result;
    logic                  alu_done;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_err;
    logic                  busy;

    // Bench state
    logic [NREQ-1:0]  req_v;
    logic [OP_W-1:0]  op_v [NREQ];
    logic [WIDTH-1:0] a_v  [NREQ];
    logic [WIDTH-1:0] b_v  [NREQ];
    exp_t             exp_g_q [$];
    exp_t             exp_r_q [$];
    int               n_vec = 0;
    int               n_mis = 0;
    int               cyc = 0;
    int               stray_cyc = -1;
    int               alu_lat = 0;
    bit               alu_hang = 1'b0;
    int               last_w = NREQ - 1;
    int               spacing_exp = 0;
    int               rsp_count = 0;

    alu_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .OP_W(OP_W), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_a(req_a),
        .req_b(req_b), .gnt(gnt), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_start(alu_start), .alu_result(alu_result), .alu_done(alu_done),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Cycle counter used for stray-done scheduling and grant spacing.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WIDTH-1:0] alu_fn(input logic [OP_W-1:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd3:    return a - b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[4:0];
            3'd6:    return a >> b[4:0];
            default: return ~(a & b);
        endcase
    endfunction

    // Reference arbitration: first asserted index after the last owner.
    function automatic int pick(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        req = req_v;
        for (int i = 0; i < NREQ; i++) begin
            req_op[i*OP_W +: OP_W]   = op_v[i];
            req_a[i*WIDTH +: WIDTH]  = a_v[i];
            req_b[i*WIDTH +: WIDTH]  = b_v[i];
        end
    endtask

    task automatic rand_ops(input int i);
        op_v[i] = OP_W'($urandom_range(0, 7));
        a_v[i]  = $urandom;
        b_v[i]  = $urandom;
    endtask

    // Behavioural ALU: answers alu_start after alu_lat cycles unless hung;
    // stray_cyc forces a done pulse with a marker result in that cycle.
    initial begin
        alu_done   = 1'b0;
        alu_result = '0;
        forever begin
            step();
            alu_done = (cyc == stray_cyc);
            if (alu_done) begin
                alu_result = 32'hDEAD_BEEF;
            end else if (alu_start && !alu_hang) begin
                repeat (alu_lat) begin
                    step();
                    alu_done = 1'b0;
                end
                alu_done   = 1'b1;
                alu_result = alu_fn(alu_op, alu_a, alu_b);
            end
        end
    end

    // Monitor: compares every grant and response against the queues.
    initial begin
        exp_t e;
        logic prev_done = 1'b0;
        int   prev_gnt_cyc = -1;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (gnt != '0) begin
                    if (exp_g_q.size() == 0) begin
                        chk("gnt_unexpected", 64'(gnt), 64'd0);
                    end else begin
                        e = exp_g_q.pop_front();
                        chk("gnt_onehot", 64'(gnt), 64'd1 << e.w);
                        chk("start_with_gnt", 64'(alu_start), 64'd1);
                        chk("alu_op", 64'(alu_op), 64'(e.op));
                        chk("alu_a", 64'(alu_a), 64'(e.a));
                        chk("alu_b", 64'(alu_b), 64'(e.b));
                        if (spacing_exp != 0 && prev_gnt_cyc >= 0)
                            chk("gnt_spacing", 64'(cyc - prev_gnt_cyc), 64'(spacing_exp));
                    end
                    prev_gnt_cyc = cyc;
                end else if (alu_start) begin
                    chk("start_without_gnt", 64'(alu_start), 64'd0);
                end
                if (rsp_valid != '0) begin
                    rsp_count++;
                    if (exp_r_q.size() == 0) begin
                        chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
                    end else begin
                        e = exp_r_q.pop_front();
                        chk("rsp_onehot", 64'(rsp_valid), 64'd1 << e.w);
                        chk("rsp_data", 64'(rsp_data), 64'(e.res));
                        chk("rsp_err", 64'(rsp_err), 64'(e.err));
                        if (!e.err) chk("rsp_one_after_done", 64'(prev_done), 64'd1);
                    end
                end
            end
            prev_done = alu_done;
        end
    end

    // One arbitration from IDLE: queue expectations, await grant, then apply
    // post-grant changes (mode 0 keep, 1 drop winner, 2 random perturb).
    task automatic one_op(input int lat, input int mode, output int w);
        exp_t e;
        int   n;
        w = pick(req_v, last_w);
        if (w < 0) return;
        e.w = w; e.op = op_v[w]; e.a = a_v[w]; e.b = b_v[w];
        e.res = alu_fn(op_v[w], a_v[w], b_v[w]); e.err = 1'b0;
        exp_g_q.push_back(e);
        exp_r_q.push_back(e);
        alu_lat = lat;
        n = 0;
        do begin step(); n++; end while (gnt == '0 && n < 8);
        chk("gnt_latency", 64'(n), 64'd1);
        last_w = w;
        rand_ops(w);
        if (mode == 1) req_v[w] = 1'b0;
        if (mode == 2) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_v[i] && i != w && $urandom_range(0, 3) == 0) req_v[i] = 1'b0;
                else if (!req_v[i] && $urandom_range(0, 1) == 1) begin
                    rand_ops(i);
                    req_v[i] = 1'b1;
                end
            end
            if ($urandom_range(0, 1) == 1) req_v[w] = 1'b0;
        end
        drive();
        n = 0;
        while (busy && n < 40) begin step(); n++; end
        chk("busy_cycles", 64'(n), 64'(lat + 2));
    endtask

    // Global time limit so the bench never hangs.
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

    initial begin
        exp_t e;
        int   w;
        int   n;
        int   cnt0;
        rst_n = 1'b0;
        req_v = '1;
        for (int i = 0; i < NREQ; i++) rand_ops(i);
        drive();

        // Reset with all requests asserted: everything quiet.
        step(); step();
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_start", 64'(alu_start), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_alu_bus", {alu_a, alu_b}, 64'd0);
        chk("rst_op_data", {29'd0, alu_op, rsp_data}, 64'd0);
        rst_n = 1'b1;

        // Round robin, zero-wait ALU: 0,1,2,3,0 spaced 3 cycles.
        spacing_exp = 3;
        for (int k = 0; k < 5; k++) begin
            one_op(0, 0, w);
            chk("rr_order", 64'(w), 64'(k % NREQ));
        end
        spacing_exp = 0;
        req_v = '0;
        drive();
        step();

        // Single AND, zero-wait.
        op_v[0] = 3'b000; a_v[0] = 32'hF0F0_00FF; b_v[0] = 32'h0FF0_0F0F;
        req_v = 4'b0001;
        drive();
        one_op(0, 1, w);
        chk("and_owner", 64'(w), 64'd0);

        // Slow ALU: done 5 cycles after start, operands changed after gnt.
        rand_ops(2);
        req_v = 4'b0100;
        drive();
        one_op(5, 1, w);
        chk("slow_owner", 64'(w), 64'd2);

        // Stray done while idle gives no response.
        cnt0 = rsp_count;
        stray_cyc = cyc + 2;
        repeat (5) step();
        chk("stray_no_rsp", 64'(rsp_count), 64'(cnt0));
        chk("stray_idle", 64'(busy), 64'd0);

        // Reset in the second WAIT cycle; late done afterwards is ignored.
        alu_hang = 1'b1;
        rand_ops(2);
        req_v = 4'b0100;
        drive();
        w = pick(req_v, last_w);
        e.w = w; e.op = op_v[w]; e.a = a_v[w]; e.b = b_v[w]; e.res = '0; e.err = 1'b0;
        exp_g_q.push_back(e);
        n = 0;
        do begin step(); n++; end while (gnt == '0 && n < 8);
        chk("midrst_gnt_latency", 64'(n), 64'd1);
        req_v = '0;
        drive();
        step();
        rst_n = 1'b0;
        cnt0 = rsp_count;
        step();
        rst_n = 1'b1;
        stray_cyc = cyc;
        last_w = NREQ - 1;
        chk("midrst_busy", 64'(busy), 64'd0);
        repeat (3) step();
        chk("midrst_no_rsp", 64'(rsp_count), 64'(cnt0));
        alu_hang = 1'b0;
        rand_ops(1); rand_ops(3);
        req_v = 4'b1010;
        drive();
        one_op(0, 1, w);
        chk("midrst_first_gnt", 64'(w), 64'd1);
        req_v = '0;
        drive();
        step();

        // Randomized traffic with random latencies and request churn.
        for (int k = 0; k < 60; k++) begin
            if (req_v == '0) begin
                req_v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
                for (int i = 0; i < NREQ; i++) if (req_v[i]) rand_ops(i);
                drive();
            end
            one_op($urandom_range(0, 4), 2, w);
        end
        req_v = '0;
        drive();
        step();

        // ALU that never answers.
        alu_hang = 1'b1;
        rand_ops(1);
        req_v = 4'b0010;
        drive();
        w = pick(req_v, last_w);
        e.w = w; e.op = op_v[w]; e.a = a_v[w]; e.b = b_v[w]; e.err = 1'b0;
        exp_g_q.push_back(e);
        n = 0;
        do begin step(); n++; end while (gnt == '0 && n < 8);
        chk("hang_gnt_latency", 64'(n), 64'd1);
        req_v = '0;
        drive();
`ifdef ALU_ARB_TIMEOUT_EN
        e.res = '0; e.err = 1'b1;
        exp_r_q.push_back(e);
        repeat (15) step();
        chk("timeout_not_early", 64'(rsp_valid), 64'd0);
        step();
        chk("timeout_rsp", 64'(rsp_valid), 64'd1 << w);
        chk("timeout_err", 64'(rsp_err), 64'd1);
        chk("timeout_data", 64'(rsp_data), 64'd0);
`else
        cnt0 = rsp_count;
        repeat (40) step();
        chk("hang_busy", 64'(busy), 64'd1);
        chk("hang_no_rsp", 64'(rsp_count), 64'(cnt0));
        e.res = 32'hDEAD_BEEF; e.err = 1'b0;
        exp_r_q.push_back(e);
        stray_cyc = cyc + 1;
`endif
        n = 0;
        while (busy && n < 40) begin step(); n++; end
        chk("hang_release", 64'(busy), 64'd0);
        alu_hang = 1'b0;
        last_w = w;

        repeat (3) step();
        chk("queues_drained", 64'(exp_g_q.size() + exp_r_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one ALU (AND/OR/ADD/... datapath) among NREQ requesters using a round-robin req/gnt handshake.
- Captures the winner's opcode and operands, issues a start pulse to the ALU, waits for done, then returns the result to the owning requester.
- Sits between CPU-side functional units (decode, address gen, branch) and the single shared ALU instance.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 32, operand/result width
OP_W, 3, ALU opcode width (3'b000 = AND)
TIMEOUT_CYC, 16, watchdog limit in cycles; used only when TIMEOUT_EN is defined

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
req  in  NREQ  per-requester request, level
req_op  in  NREQ*OP_W  opcodes, requester i at [i*OP_W +: OP_W]
req_a  in  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
req_b  in  NREQ*WIDTH  operand B, same packing
gnt  out  NREQ  one-hot grant pulse; operands captured
alu_op  out  OP_W  opcode to ALU
alu_a  out  WIDTH  operand A to ALU
alu_b  out  WIDTH  operand B to ALU
alu_start  out  1  one-cycle start pulse
alu_result  in  WIDTH  ALU result, valid with alu_done
alu_done  in  1  ALU completion strobe
rsp_valid  out  NREQ  one-hot response pulse to owner
rsp_data  out  WIDTH  result, valid with rsp_valid
rsp_err  out  1  error flag, valid with rsp_valid (timeout)
busy  out  1  high in WAIT and RESP

Behaviour:
- One clock; reset is synchronous and active-low. All outputs are registered.
- Reset (rst_n=0 at an edge): state=IDLE; gnt, alu_start, rsp_valid, rsp_err, busy = 0; alu_op/alu_a/alu_b/rsp_data = 0; owner=0; ptr=NREQ-1, so req[0] wins first.
- FSM states: IDLE, WAIT, RESP.
- IDLE: if req != 0, search indices ptr+1 .. ptr+NREQ (mod NREQ); the first asserted index is the winner w. At the next edge:
  - gnt[w]=1 and alu_start=1, both for exactly one cycle.
  - alu_op/alu_a/alu_b are loaded from w's slices; owner=w; busy=1; state goes to WAIT.
  - If req == 0, remain in IDLE with all pulses 0.
- WAIT: alu_op/a/b are held stable. alu_done is sampled every WAIT cycle, including the cycle in which alu_start is high (zero-wait ALU). On done at the next edge:
  - rsp_data=alu_result, rsp_valid[owner]=1, rsp_err=0, ptr=owner; state goes to RESP.
- RESP: rsp_valid/rsp_data are held for this one cycle. At the next edge: rsp_valid=0, busy=0, state goes to IDLE. No arbitration occurs in RESP.
- Latency:
  - req seen at T gives gnt/alu_start at T+1.
  - done at cycle D gives rsp_valid at D+1.
  - Minimum req-to-rsp is 2 cycles. Peak throughput is 1 op per 3 cycles.
- Requester rules:
  - Operands must be stable while req is high and gnt is not yet received. They may change after gnt.
  - A req still high in the IDLE cycle after RESP is a new request.
  - Dropping req before gnt withdraws it without side effect.
- alu_done outside WAIT is ignored.
- alu_result is sampled only on done.
- Fairness: with all requesters asserted, grants rotate 0,1,...,NREQ-1,0. A single requester re-requesting continuously is granted every 3 cycles.
- Reset mid-operation (WAIT or RESP): the operation is abandoned and no rsp_valid is issued. A late alu_done after reset is ignored because the state is IDLE.

Optional Feature:
- Macro: ALU_ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to WAIT and increments each WAIT cycle without done.
  - When the count reaches TIMEOUT_CYC without done, the next edge sets rsp_valid[owner]=1, rsp_data=0, rsp_err=1, ptr=owner, and state goes to RESP.
  - A done in the same cycle as the limit takes priority (normal response, rsp_err=0).
- Not defined: no counter; WAIT persists until done; rsp_err is tied 0.

Test Plan:
- Reset: rst_n=0 for 2 cycles with req=4'b1111 -> all outputs 0, no gnt; first grant after release is gnt=4'b0001.
- Single AND: req=4'b0001, op=3'b000, a=32'hF0F0_00FF, b=32'h0FF0_0F0F, ALU model asserts done together with start -> gnt=0001 and alu_start at T+1, rsp_valid=0001 with rsp_data=32'h00F0_000F at T+2, busy high T+1..T+2.
- Round robin: req=4'b1111 held, zero-wait ALU -> gnt sequence 0001, 0010, 0100, 1000, 0001, with grants spaced 3 cycles apart; each rsp_valid goes to the matching owner.
- Slow ALU: req=4'b0100, done asserted 5 cycles after start, operands changed after gnt -> alu_op/a/b unchanged throughout WAIT; rsp_valid=0100 exactly 1 cycle after done; a stray done in IDLE produces no response.
- Reset mid-op: reset in 2nd WAIT cycle, done asserted next cycle -> no rsp_valid, ptr reset; req=4'b1010 afterwards -> gnt=0010.
- Timeout (ALU_ARB_TIMEOUT_EN, TIMEOUT_CYC=16): done never asserted -> rsp_valid[owner]=1, rsp_err=1, rsp_data=0 on cycle 17 after WAIT entry. Without the macro, busy stays 1 indefinitely until done.
